// File: rtl/s_64bit_unfold.sv
// s_64bit_unfold: rebuilds 64-bit a/b operands from XOR-folded 32-bit lanes.
// Each lane is reconstructed as {folded ^ low, low} when the beat is accepted.
// The rebuilt beat is then stored in a small elastic output buffer.
// Valid/ready: a beat moves on a rising edge only when valid and ready are
// both high. in_ready depends on registered occupancy only, never on out_ready.
// Optional parity checking is enabled by defining S64_UNFOLD_PARITY_EN.
module s_64bit_unfold #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_aa,
  input  logic [31:0]      in_bb,
  input  logic [31:0]      in_alo,
  input  logic [31:0]      in_blo,
  input  logic [1:0]       in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_a,
  output logic [63:0]      out_b,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             par_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [63:0]      a_mem_q [DEPTH];
  logic [63:0]      a_mem_d [DEPTH];
  logic [63:0]      b_mem_q [DEPTH];
  logic [63:0]      b_mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;
  logic [63:0]      rec_a, rec_b;

  assign rec_a = {in_aa ^ in_alo, in_alo};
  assign rec_b = {in_bb ^ in_blo, in_blo};

  assign in_ready  = (occ_q < OCC_FULL);
  assign out_valid = (occ_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_a    = a_mem_q[head_q];
  assign out_b    = b_mem_q[head_q];
  assign beat_cnt = cnt_q;

  // Next-state for buffer storage, pointers, occupancy and beat counter.
  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    cnt_d   = cnt_q;
    if (push) begin
      a_mem_d[tail_q] = rec_a;
      b_mem_d[tail_q] = rec_b;
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
    end
    if (pop) begin
      head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset clears storage so out_a/out_b read back as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_mem_q[i] <= '0;
        b_mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
    end else begin
      a_mem_q <= a_mem_d;
      b_mem_q <= b_mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef S64_UNFOLD_PARITY_EN
  logic err_mem_q [DEPTH];
  logic err_mem_d [DEPTH];
  logic par_err_q, par_err_d;
  logic rec_mis;

  assign rec_mis = ((^rec_a) != in_par[0]) | ((^rec_b) != in_par[1]);
  assign par_err = par_err_q;

  // Per-entry mismatch bit travels with the data; the flag is sticky on pop.
  always_comb begin
    err_mem_d = err_mem_q;
    if (push) err_mem_d[tail_q] = rec_mis;
    par_err_d = par_err_q | (pop & err_mem_q[head_q]);
  end

  // Parity state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) err_mem_q[i] <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      err_mem_q <= err_mem_d;
      par_err_q <= par_err_d;
    end
  end
`else
  logic unused_par;
  assign unused_par = ^in_par;
  assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_s_64bit_unfold.sv
// Bench for s_64bit_unfold: scoreboard of reconstructed beats plus directed
// checks for reset, backpressure, streaming, counter wrap, parity, mid reset.
module tb_s_64bit_unfold;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_aa, in_bb, in_alo, in_blo;
  logic [1:0]  in_par;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a, out_b;
  logic [15:0] beat_cnt;
  logic        par_err;

  logic        w4_unused_in_ready;
  logic        w4_unused_out_valid;
  logic [63:0] w4_unused_out_a, w4_unused_out_b;
  logic [3:0]  w4_beat_cnt;
  logic        w4_unused_par_err;

  logic [127:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit stream_on = 0;
  int gaps = 0;

  s_64bit_unfold #(.DEPTH(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aa(in_aa), .in_bb(in_bb), .in_alo(in_alo), .in_blo(in_blo),
    .in_par(in_par),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .beat_cnt(beat_cnt), .par_err(par_err)
  );

  // Narrow-counter instance for the wrap check; fed the same stimulus.
  s_64bit_unfold #(.DEPTH(2), .CNT_W(4)) u_dut_w4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(w4_unused_in_ready),
    .in_aa(in_aa), .in_bb(in_bb), .in_alo(in_alo), .in_blo(in_blo),
    .in_par(in_par),
    .out_valid(w4_unused_out_valid), .out_ready(out_ready),
    .out_a(w4_unused_out_a), .out_b(w4_unused_out_b),
    .beat_cnt(w4_beat_cnt), .par_err(w4_unused_par_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] good_par(input logic [31:0] aa, input logic [31:0] alo,
                                          input logic [31:0] bb, input logic [31:0] blo);
    logic [63:0] a, b;
    a = {aa ^ alo, alo};
    b = {bb ^ blo, blo};
    return {^b, ^a};
  endfunction

  // Driver: present a beat, wait (bounded) for acceptance, record expectation.
  // Returns at posedge+1 with in_valid still high.
  task automatic send(input logic [31:0] aa, input logic [31:0] alo,
                      input logic [31:0] bb, input logic [31:0] blo, input logic [1:0] par);
    bit ok;
    int t;
    in_aa = aa; in_alo = alo; in_bb = bb; in_blo = blo; in_par = par;
    in_valid = 1'b1;
    t = 0;
    ok = 0;
    while (!ok && t < 20) begin
      ok = in_ready;
      @(posedge clk);
      t++;
    end
    if (!ok) check("send_timeout", 0, 1);
    else exp_q.push_back({{aa ^ alo, alo}, {bb ^ blo, blo}});
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_aa = $urandom; in_alo = $urandom; in_bb = $urandom; in_blo = $urandom;
    in_par = 2'($urandom_range(0, 3));
  endtask

  task automatic send_rand();
    logic [31:0] aa, alo, bb, blo;
    aa = $urandom; alo = $urandom; bb = $urandom; blo = $urandom;
    send(aa, alo, bb, blo, good_par(aa, alo, bb, blo));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each delivered beat against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stream_on && !out_valid) gaps++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
        else check("beat_ab", {out_a, out_b}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle();
    #12;
    // Reset values
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ab", {out_a, out_b}, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_par_err", par_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat
    out_ready = 1'b1;
    send(32'h88888888, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h0000FFFF, 2'b00);
    idle();
    check("single_valid", out_valid, 1);
    check("single_a", out_a, 64'h0123456789ABCDEF);
    check("single_b", out_b, 64'hFFFF00000000FFFF);
    @(posedge clk);
    #1;
    check("single_cnt", beat_cnt, 1);
    check("single_par_err", par_err, 0);

    // Backpressure: third beat stalls until a slot frees
    out_ready = 1'b0;
    send_rand();
    send_rand();
    check("bp_full_ready", in_ready, 0);
    in_aa = 32'h1111_2222; in_alo = 32'h3333_4444;
    in_bb = 32'h5555_6666; in_blo = 32'h7777_8888;
    in_par = good_par(in_aa, in_alo, in_bb, in_blo);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_stall_ready", in_ready, 0);
    check("bp_stall_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_after_pop", in_ready, 1);
    exp_q.push_back({{in_aa ^ in_alo, in_alo}, {in_bb ^ in_blo, in_blo}});
    @(posedge clk);
    #1;
    idle();
    wait_drain();
    check("bp_cnt", beat_cnt, 4);

    // Streaming 100 beats
    begin
      logic [15:0] base;
      base = beat_cnt;
      gaps = 0;
      send_rand();
      stream_on = 1;
      for (int i = 1; i < 100; i++) send_rand();
      stream_on = 0;
      idle();
      wait_drain();
      check("stream_gaps", gaps, 0);
      check("stream_cnt", beat_cnt - base, 100);
    end

    // Reset mid-operation
    out_ready = 1'b0;
    send_rand();
    send_rand();
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cnt", beat_cnt, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_ab", {out_a, out_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_stale", out_valid, 0);
    end

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 17; i++) send_rand();
    idle();
    wait_drain();
    check("wrap_cnt16", beat_cnt, 17);
    check("wrap_cnt4", w4_beat_cnt, 1);

    // Parity
    rst_n = 1'b0;
    #2;
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h88888888, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h0000FFFF, 2'b01);
    idle();
    wait_drain();
`ifdef S64_UNFOLD_PARITY_EN
    check("par_set", par_err, 1);
    for (int i = 0; i < 5; i++) send_rand();
    idle();
    wait_drain();
    check("par_sticky", par_err, 1);
`else
    check("par_disabled", par_err, 0);
    for (int i = 0; i < 5; i++) send_rand();
    idle();
    wait_drain();
    check("par_disabled_after", par_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/s_64bit_unfold.md
Name: s_64bit_unfold

Overview:
Inverse of the 64-to-32 XOR fold used on the a/b operand lanes. Each lane receives a folded 32-bit word together with the original low half, and the block rebuilds the full 64-bit operand as {folded ^ low, low}. The block is a valid/ready elastic stage with a 2-entry output buffer and a beat counter. It sits on the consumer side of the folded operand bus.

Parameters:
DEPTH, 2, output buffer entries; legal values are 2 or 4.
CNT_W, 16, width of the delivered-beat counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_aa  input  32  folded a lane (a_lo ^ a_hi)
in_bb  input  32  folded b lane (b_lo ^ b_hi)
in_alo  input  32  original a[31:0]
in_blo  input  32  original b[31:0]
in_par  input  2  [0] = XOR-reduce of original a[63:0]; [1] = XOR-reduce of original b[63:0]
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the beat
out_a  output  64  reconstructed a
out_b  output  64  reconstructed b
beat_cnt  output  CNT_W  count of delivered output beats
par_err  output  1  sticky parity mismatch flag

Behaviour:
- Reset (async assert, sync deassert handled upstream) values:
  - buffer empty, so out_valid=0;
  - out_a and out_b = 0;
  - in_ready=1 (the first cycle after release accepts);
  - beat_cnt=0;
  - par_err=0.
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- Reconstruction is applied at push time:
  - a = {in_aa ^ in_alo, in_alo};
  - b = {in_bb ^ in_blo, in_blo}.
  - The result is written to the buffer tail.
- Latency: a beat pushed on edge N is presented at out_valid/out_a/out_b after edge N, i.e. out_valid is visible in cycle N+1.
- Throughput: 1 beat/cycle while out_ready=1.
- out_a and out_b are driven from the head entry. They are held stable while out_valid=1 and out_ready=0.
- Occupancy counter (0..DEPTH):
  - push only: +1; pop only: -1; push and pop together: unchanged.
  - in_ready = (occupancy < DEPTH), taken from registered state only; there is no combinational path from out_ready to in_ready.
  - Full (occupancy == DEPTH): in_ready=0. A pop that cycle frees one slot, so in_ready=1 in the next cycle.
  - Empty with a push: out_valid=1 next cycle. There is no bypass in the same cycle.
- Head and tail pointers wrap modulo DEPTH.
- beat_cnt increments by 1 per pop and wraps from 2^CNT_W-1 to 0.
- in_valid=0 with don't-care data must not alter state.
- Asserting rst_n mid-traffic discards all buffered beats immediately. Outputs return to their reset values asynchronously.

Optional Feature:
Macro S64_UNFOLD_PARITY_EN.
- Defined:
  - at push, compute XOR-reduce of the reconstructed a and b;
  - compare with in_par[0] and in_par[1];
  - store a per-entry mismatch bit alongside the data;
  - on the pop of an entry with a mismatch, set par_err=1. It stays set until reset.
- Undefined:
  - in_par is ignored;
  - par_err is tied to 0;
  - no parity storage is synthesised.

Test Plan:
- Single beat: in_aa=88888888, in_alo=89ABCDEF, in_bb=FFFFFFFF, in_blo=0000FFFF, in_par=2'b00, out_ready=1 -> next cycle out_valid=1, out_a=0123456789ABCDEF, out_b=FFFF00000000FFFF; beat_cnt=1; par_err=0.
- Backpressure: out_ready=0, push 3 beats with DEPTH=2 -> in_ready=0 after the 2nd push and the 3rd is stalled. Raise out_ready -> beats emerge in order, and the 3rd is accepted the cycle after the first pop.
- Streaming: 100 back-to-back beats with random data and out_ready=1 -> out_valid is continuous after the first cycle; every out_a[63:32] == aa ^ alo; beat_cnt=100.
- Counter wrap: CNT_W=4, 17 pops -> beat_cnt=1.
- Parity (macro defined): the single-beat case with in_par=2'b01 -> par_err=1 after that pop and still 1 after 5 further clean beats. With the macro undefined -> par_err stays 0.
- Reset mid-operation: 2 beats buffered, pulse rst_n low -> out_valid=0, beat_cnt=0, in_ready=1. No stale beat appears after release.
